// File: rtl/line_window_buffer.sv
// Streaming line buffer: for every accepted pixel it emits the vertical column
// of NUM_ROWS pixels at the same x, gathered from the current line and the
// previous NUM_ROWS-1 lines. Rows not yet received in the current frame are
// zero-filled or replicated from the oldest real row (BORDER_MODE).
module line_window_buffer #(
  parameter int DATA_WIDTH  = 12,
  parameter int LINE_WIDTH  = 640,
  parameter int NUM_ROWS    = 3,
  parameter int BORDER_MODE = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_sof,
  input  logic                           in_eol,
  input  logic [DATA_WIDTH-1:0]          pixel_in,
  output logic [NUM_ROWS*DATA_WIDTH-1:0] col_out,
  output logic                           out_valid,
  output logic                           out_eol,
  output logic                           out_window_valid,
  output logic                           err_overflow
);

  localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int RW = $clog2(NUM_ROWS);
  localparam int NM = NUM_ROWS - 1;
  localparam logic [AW-1:0] LAST_COL = AW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] FULL_RF  = RW'(NUM_ROWS - 1);

  // Line memories; mem[0] holds the previous line, mem[NM-1] the oldest.
  logic [DATA_WIDTH-1:0] mem [NM][LINE_WIDTH];

  logic [AW-1:0]                  col_cnt;
  logic [RW-1:0]                  rows_filled;
  logic [AW-1:0]                  addr_p0;
  logic [RW-1:0]                  rf_p0;
  logic                           wrap_p0;
  logic                           line_end_p0;
  logic [DATA_WIDTH-1:0]          tap_p0 [NUM_ROWS];
  logic [NUM_ROWS*DATA_WIDTH-1:0] col_p0;

  // Count of completed lines, saturating once every window row is real.
  function automatic logic [RW-1:0] rf_advance(input logic [RW-1:0] rf);
    return (rf < FULL_RF) ? rf + RW'(1) : rf;
  endfunction

  // Stage p0: start-of-frame overrides address/row count, read taps, apply border.
  always_comb begin
    addr_p0     = in_sof ? '0 : col_cnt;
    rf_p0       = in_sof ? '0 : rows_filled;
    wrap_p0     = !in_eol && (addr_p0 == LAST_COL);
    line_end_p0 = in_eol || wrap_p0;
    tap_p0[0]   = pixel_in;
    for (int k = 1; k < NUM_ROWS; k++) begin
      tap_p0[k] = mem[k-1][addr_p0];
    end
    col_p0 = '0;
    for (int k = 0; k < NUM_ROWS; k++) begin
      if (k <= int'(rf_p0)) begin
        col_p0[k*DATA_WIDTH +: DATA_WIDTH] = tap_p0[k];
      end else if (BORDER_MODE == 1) begin
        col_p0[k*DATA_WIDTH +: DATA_WIDTH] = tap_p0[rf_p0];
      end
    end
  end

  // Shift the column down one memory: each line memory takes the row above it.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int k = 0; k < NM; k++) begin
        mem[k][addr_p0] <= tap_p0[k];
      end
    end
  end

  // Column address, completed-line count and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt      <= '0;
      rows_filled  <= '0;
      err_overflow <= 1'b0;
    end else if (in_valid) begin
      col_cnt     <= line_end_p0 ? '0 : addr_p0 + AW'(1);
      rows_filled <= line_end_p0 ? rf_advance(rf_p0) : rf_p0;
      if (wrap_p0) begin
        err_overflow <= 1'b1;
      end
    end
  end

  // Stage p1: registered outputs; col_out holds across input gaps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_out          <= '0;
      out_valid        <= 1'b0;
      out_eol          <= 1'b0;
      out_window_valid <= 1'b0;
    end else begin
      out_valid        <= in_valid;
      out_eol          <= in_valid && in_eol;
      out_window_valid <= in_valid && (rf_p0 == FULL_RF);
      if (in_valid) begin
        col_out <= col_p0;
      end
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer with LINE_WIDTH=4, NUM_ROWS=3.
// Two instances (zero-fill and replicate border) share one input stream.
module tb_line_window_buffer;

  localparam int DW = 12;
  localparam int LW = 4;
  localparam int NR = 3;
  localparam int CW = NR * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_eol = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic [CW-1:0] col0, col1;
  logic          ov0, ov1, oe0, oe1, wv0, wv1, er0, er1;

  always #5 clk = ~clk;

  line_window_buffer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .NUM_ROWS(NR), .BORDER_MODE(0)) u_zero (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
    .pixel_in(pixel_in), .col_out(col0), .out_valid(ov0), .out_eol(oe0),
    .out_window_valid(wv0), .err_overflow(er0));

  line_window_buffer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .NUM_ROWS(NR), .BORDER_MODE(1)) u_rep (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
    .pixel_in(pixel_in), .col_out(col1), .out_valid(ov1), .out_eol(oe1),
    .out_window_valid(wv1), .err_overflow(er1));

  int checks = 0;
  int errors = 0;

  // Reference model state: frame row, x position, pixels seen this frame.
  int            fr = 0;
  int            cx = 0;
  logic [DW-1:0] hist [0:7][0:LW-1];
  logic          err_exp = 1'b0;
  logic [CW-1:0] last0 = '0;
  logic [CW-1:0] last1 = '0;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected column for the pixel at (fr, cx); rows above the frame top are
  // zero or copies of frame row 0.
  function automatic logic [CW-1:0] exp_col(input int mode);
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < NR; k++) begin
      if (fr - k >= 0) c[k*DW +: DW] = hist[fr-k][cx];
      else if (mode == 1) c[k*DW +: DW] = hist[0][cx];
    end
    return c;
  endfunction

  task automatic model_reset();
    fr = 0; cx = 0; err_exp = 1'b0; last0 = '0; last1 = '0;
  endtask

  task automatic px(input logic [DW-1:0] v, input logic sof, input logic eol);
    logic [CW-1:0] e0, e1;
    logic          wrap, w;
    @(negedge clk);
    in_valid = 1'b1; in_sof = sof; in_eol = eol; pixel_in = v;
    if (sof) begin fr = 0; cx = 0; end
    hist[fr][cx] = v;
    e0 = exp_col(0);
    e1 = exp_col(1);
    w = (fr >= NR - 1);
    wrap = !eol && (cx == LW - 1);
    if (wrap) err_exp = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    chk("col_zero", col0, e0);
    chk("col_rep", col1, e1);
    chk("out_valid", {34'd0, ov0, ov1}, {34'd0, 2'b11});
    chk("out_eol", {34'd0, oe0, oe1}, {34'd0, eol, eol});
    chk("window_valid", {34'd0, wv0, wv1}, {34'd0, w, w});
    chk("err_overflow", {34'd0, er0, er1}, {34'd0, err_exp, err_exp});
    last0 = e0; last1 = e1;
    if (eol || wrap) begin
      cx = 0;
      if (fr < 7) fr++;
    end else begin
      cx++;
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      chk("gap_valid", {34'd0, ov0, ov1}, 36'd0);
      chk("gap_eol", {34'd0, oe0, oe1}, 36'd0);
      chk("gap_window", {34'd0, wv0, wv1}, 36'd0);
      chk("gap_hold_zero", col0, last0);
      chk("gap_hold_rep", col1, last1);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_col_zero", col0, '0);
    chk("rst_col_rep", col1, '0);
    chk("rst_flags", {31'd0, ov0, oe0, wv0, er0, ov1}, 36'd0);
    @(negedge clk); rst = 1'b1;

    // Asynchronous reset in the middle of a line
    px(12'h0AA, 1'b1, 1'b0);
    px(12'h0BB, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_col", col0, '0);
    chk("async_rst_flags", {32'd0, ov0, oe0, wv0, er0}, 36'd0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    px(12'h055, 1'b0, 1'b0);
    chk("post_rst_zero", col0, {24'h0, 12'h055});
    chk("post_rst_rep", col1, {12'h055, 12'h055, 12'h055});

    // Gapless 4x4 frame
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < LW; c++) begin
        px(DW'(r * 16 + c), (r == 0 && c == 0), (c == LW - 1));
        if (r == 0 && c == 2) begin
          chk("fill_r0x2", col0, 36'h000_000_002);
          chk("border_r0x2", col1, 36'h002_002_002);
        end
        if (r == 1 && c == 0) chk("border_r1x0", col1, 36'h000_000_010);
        if (r == 2 && c == 1) begin
          chk("fill_r2x1", col0, 36'h001_011_021);
          chk("fill_r2x1_wv", {35'd0, wv0}, 36'd1);
        end
        if (r == 2 && c == 3) chk("fill_r2x3_eol", {35'd0, oe0}, 36'd1);
      end
    end

    // Same frame with random input gaps
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < LW; c++) begin
        if ($urandom_range(0, 1) == 1) gap(int'($urandom_range(1, 3)));
        px(DW'(r * 16 + c), (r == 0 && c == 0), (c == LW - 1));
      end
    end

    // Resync: new start-of-frame at what would have been row 2
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < LW; c++) begin
        px(DW'(r * 16 + c), ((r == 0 || r == 2) && c == 0), (c == LW - 1));
        if (r == 2 && c == 0) begin
          chk("resync_zero", col0, 36'h000_000_020);
          chk("resync_wv", {35'd0, wv0}, 36'd0);
        end
        if (r == 4 && c == 0) chk("resync_third_wv", {35'd0, wv0}, 36'd1);
      end
    end

    // Overflow: five pixels without end-of-line
    px(12'h000, 1'b1, 1'b0);
    px(12'h001, 1'b0, 1'b0);
    px(12'h002, 1'b0, 1'b0);
    chk("ovf_not_yet", {35'd0, er0}, 36'd0);
    px(12'h003, 1'b0, 1'b0);
    px(12'h004, 1'b0, 1'b0);
    chk("ovf_flag", {35'd0, er0}, 36'd1);
    chk("ovf_wrap_col", col0, 36'h000_000_004);
    px(12'h005, 1'b0, 1'b0);
    px(12'h006, 1'b0, 1'b0);
    px(12'h007, 1'b0, 1'b1);
    px(12'h008, 1'b0, 1'b0);
    chk("ovf_rows_col", col0, 36'h000_004_008);
    chk("ovf_rows_wv", {35'd0, wv0}, 36'd1);
    chk("ovf_sticky", {35'd0, er1}, 36'd1);
    #2 rst = 1'b0;
    #1;
    chk("ovf_cleared", {34'd0, er0, er1}, 36'd0);
    model_reset();
    @(negedge clk); rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Parametrised streaming line buffer for the pixel pipeline; generalises the fixed 3-row, 12-bit row buffer.
- Each accepted pixel produces a vertical column of NUM_ROWS pixels at the same x position from the current and previous lines, for downstream KxK window/convolution stages.
- Supports variable line length, start-of-frame resynchronisation, input gaps, top-border handling (zero or replicate), and overflow detection.

Parameters:
- DATA_WIDTH, 12: bits per pixel.
- LINE_WIDTH, 640: maximum pixels per line; depth of each line memory.
- NUM_ROWS, 3: column height (window rows), >= 2; uses NUM_ROWS-1 line memories.
- BORDER_MODE, 0: 0 = zero-fill rows not yet received in the frame; 1 = replicate the oldest received row.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  pixel_in is valid this cycle; the only advance condition.
- in_sof  input  1  qualified by in_valid; pixel is x=0 of row 0 of a new frame.
- in_eol  input  1  qualified by in_valid; pixel is the last pixel of its line.
- pixel_in  input  DATA_WIDTH  input pixel.
- col_out  output  NUM_ROWS*DATA_WIDTH  column; row k at [k*DATA_WIDTH +: DATA_WIDTH], k=0 = current line, k=NUM_ROWS-1 = oldest.
- out_valid  output  1  col_out valid.
- out_eol  output  1  column is the last of its line.
- out_window_valid  output  1  out_valid and all NUM_ROWS rows hold real frame data.
- err_overflow  output  1  sticky; a line exceeded LINE_WIDTH without in_eol.

Behaviour:
- Reset: col_out=0, out_valid=0, out_eol=0, out_window_valid=0, err_overflow=0; col_cnt=0, rows_filled=0. Line memory contents are not reset; border masking hides stale data.
- Latency: one cycle. Outputs are registered from the accepted pixel at cycle t and appear at t+1.
- Gaps: when in_valid=0, no state advances. The next cycle has out_valid=0, out_eol=0, out_window_valid=0, and col_out holds its last value.
- Line memories: NUM_ROWS-1 circular RAMs of LINE_WIDTH x DATA_WIDTH share address col_cnt.
  - On an accepted pixel, tap[0]=pixel_in and tap[k]=mem[k-1][col_cnt] (read-before-write).
  - Then mem[0][col_cnt]<=pixel_in and mem[k][col_cnt]<=old mem[k-1][col_cnt], in the same cycle.
- Column counter (effective address = 0 when in_sof is set):
  - in_eol: col_cnt<=0.
  - Otherwise, if col_cnt==LINE_WIDTH-1: col_cnt<=0 and err_overflow<=1. Sticky; cleared only by rst.
  - Otherwise: col_cnt<=col_cnt+1.
- rows_filled: complete lines since the last sof, saturating at NUM_ROWS-1.
  - in_sof: rows_filled used for this pixel is 0.
  - Increments after any accepted in_eol (or overflow wrap) while < NUM_ROWS-1.
  - in_sof together with in_eol: the line is treated as row 0, rows_filled becomes 1.
- Border (rf = rows_filled used for the current pixel):
  - Rows k <= rf: tap[k].
  - Rows k > rf, BORDER_MODE=0: 0.
  - Rows k > rf, BORDER_MODE=1: tap[rf].
- out_window_valid = accepted pixel and rf==NUM_ROWS-1.
- Short lines: a line shorter than the previous one reuses the leftmost addresses; older rows stay column-aligned by x.
- Reset mid-frame: all state clears; the next pixel without in_sof is treated as row 0, x=0.

Test Plan (LINE_WIDTH=4, NUM_ROWS=3, DATA_WIDTH=12, pixel = row*16+col):
- Reset: assert rst=0 mid-stream -> all outputs 0 the same cycle (async); first pixel after release gives col_out k=0 equal to the pixel, out_window_valid=0.
- Fill, BORDER_MODE=0: 4x4 frame, continuous valid, sof on 0x00, eol on x=3. Required responses:
  - Row 0 x=2 -> col_out {0,0,0x002}.
  - Row 2 x=1 -> {0x001,0x011,0x021}, out_window_valid=1.
  - Row 2 x=3 -> out_eol=1.
- Border, BORDER_MODE=1: same stream. Required responses:
  - Row 0 x=2 -> {0x002,0x002,0x002}.
  - Row 1 x=0 -> {0x000,0x000,0x010}.
  - out_window_valid=0 for both.
- Gaps: random in_valid deassertion (1-3 cycles). Required responses:
  - Accepted columns are identical to the gapless run.
  - out_valid=0 on gap cycles, and col_out holds during them.
- Resync: in_sof at row 2 x=0 -> rows_filled restarts; out_window_valid=0 for the next two lines, and zero-fill appears in rows 1-2 for the first line.
- Overflow: 5 pixels without eol (0x0..0x4) -> err_overflow=1 after the 5th; 5th pixel written at x=0, rows_filled increments; flag stays 1 until rst.
